// File: rtl/gp_operand_stage_if.sv
// Operand-stage handshake bundle: upstream A/B beat in, registered G/P/Cin beat out.
// The stage uses the slave modport; the producer/consumer side uses master.
interface gp_operand_stage_if #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 8
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_g;
    logic [WIDTH-1:0] out_p;
    logic             out_cin;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  flush, in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_g, out_p, out_cin, out_tag
    );

    modport master (
        output flush, in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_g, out_p, out_cin, out_tag
    );
endinterface

// File: rtl/gp_operand_stage.sv
// Registered generate/propagate front-end for the lookahead adder, with sequence tags.
// Define GP_STAGE_SKID_EN for a main+skid buffer with registered in_ready.

// One bit slice: B is conditionally inverted for subtract, then G/P formed bitwise.
module gp_operand_cell (
    input  logic a,
    input  logic b,
    input  logic sub,
    output logic g,
    output logic p
);
    logic b_eff;
    assign b_eff = b ^ sub;
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;
endmodule

module gp_operand_stage #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    gp_operand_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             cin;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic [WIDTH-1:0] nxt_g;
    logic [WIDTH-1:0] nxt_p;
    beat_t            nxt_beat;
    beat_t            main_q;
    logic             main_vld;
    logic [TAG_W-1:0] tag_q;
    logic             accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        gp_operand_cell u_cell (
            .a   (bus.in_a[i]),
            .b   (bus.in_b[i]),
            .sub (bus.in_sub),
            .g   (nxt_g[i]),
            .p   (nxt_p[i])
        );
    end

    always_comb begin
        nxt_beat     = '0;
        nxt_beat.g   = nxt_g;
        nxt_beat.p   = nxt_p;
        nxt_beat.cin = bus.in_sub ? 1'b1 : bus.in_cin;
        nxt_beat.tag = tag_q;
    end

    assign accept = bus.in_valid && bus.in_ready;

    // Flush leaves the counter alone so tags stay unique across a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag_q <= '0;
        else if (accept)
            tag_q <= tag_q + 1'b1;
    end

`ifdef GP_STAGE_SKID_EN
    beat_t skid_q;
    logic  skid_vld;

    // in_ready depends only on state (and flush), so out_ready never reaches it.
    assign bus.in_ready = !skid_vld && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            main_vld <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else if (bus.flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || bus.out_ready) begin
            // Main is free this cycle: the older skid beat always wins it.
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= nxt_beat;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= nxt_beat;
            skid_vld <= 1'b1;
        end
    end
`else
    assign bus.in_ready = (!main_vld || bus.out_ready) && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            main_vld <= 1'b0;
        end else if (bus.flush) begin
            main_vld <= 1'b0;
        end else if (accept) begin
            main_q   <= nxt_beat;
            main_vld <= 1'b1;
        end else if (bus.out_ready) begin
            main_vld <= 1'b0;
        end
    end
`endif

    assign bus.out_valid = main_vld;
    assign bus.out_g     = main_q.g;
    assign bus.out_p     = main_q.p;
    assign bus.out_cin   = main_q.cin;
    assign bus.out_tag   = main_q.tag;
endmodule

// File: tb/tb_gp_operand_stage.sv
// Scoreboard bench for gp_operand_stage: driver pushes expected beats, monitor pops on delivery.
// Build with or without GP_STAGE_SKID_EN; backpressure expectations follow the macro.
module tb_gp_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gp_operand_stage_if #(.WIDTH(4), .TAG_W(8)) bus ();

    gp_operand_stage #(.WIDTH(4), .TAG_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] g;
        logic [3:0] p;
        logic       cin;
        logic [7:0] tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_tag = 8'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] p, input logic c);
        exp_t e;
        e.g = g; e.p = p; e.cin = c; e.tag = exp_tag;
        sb.push_back(e);
        exp_tag = exp_tag + 8'd1;
    endtask

    // Offer one beat until accepted (bounded); expected G/P/Cin come from the caller.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic s, input logic c,
                        input logic [3:0] eg, input logic [3:0] ep, input logic ec);
        bit ok = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = s; bus.in_cin = c;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push(eg, ep, ec);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_model(input logic [3:0] a, input logic [3:0] b, input logic s, input logic c);
        logic [3:0] bp;
        bp = s ? ~b : b;
        send(a, b, s, c, a & bp, a ^ bp, s ? 1'b1 : c);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_tag = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every delivery must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got tag %0d, expected no beat", bus.out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out_g !== e.g || bus.out_p !== e.p || bus.out_cin !== e.cin ||
                    bus.out_tag !== e.tag) begin
                    n_bad++;
                    $display("FAIL beat: got g=%b p=%b cin=%b tag=%0d, expected g=%b p=%b cin=%b tag=%0d",
                             bus.out_g, bus.out_p, bus.out_cin, bus.out_tag, e.g, e.p, e.cin, e.tag);
                end
            end
        end
    end

    initial begin
        int         held;
        int         k;
        logic [3:0] hold_g;
        logic [7:0] hold_tag;
        logic [3:0] a4;
        logic [3:0] b4;
        logic [3:0] bp;
        bus.flush = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
        bus.in_sub = 0; bus.in_cin = 0; bus.out_ready = 1;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_g", bus.out_g, 0);
        check("rst_out_p", bus.out_p, 0);
        check("rst_out_cin", bus.out_cin, 0);
        check("rst_out_tag", bus.out_tag, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);

        // Add then subtract, hand-computed
        send(4'b1011, 4'b0110, 1'b0, 1'b0, 4'b0010, 4'b1101, 1'b0);
        check("latency_out_valid", bus.out_valid, 1);
        send(4'd5, 4'd3, 1'b1, 1'b0, 4'b0100, 4'b1001, 1'b1);
        wait_drain();

        // Backpressure: offer beats for 3 cycles with out_ready low
        bus.out_ready = 1'b0;
        held = 0; k = 0;
        for (int c = 0; c < 3; c++) begin
            a4 = 4'(k + 3); b4 = 4'(k * 5 + 1);
            bus.in_valid = 1'b1; bus.in_a = a4; bus.in_b = b4; bus.in_sub = 1'b0; bus.in_cin = 1'(k);
            @(negedge clk);
            if (bus.in_ready) begin
                push(a4 & b4, a4 ^ b4, 1'(k));
                held++; k++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
`ifdef GP_STAGE_SKID_EN
        check("bp_held", held, 2);
`else
        check("bp_held", held, 1);
`endif
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        hold_g = bus.out_g; hold_tag = bus.out_tag;
        @(posedge clk); #1;
        check("stall_hold_g", bus.out_g, hold_g);
        check("stall_hold_tag", bus.out_tag, hold_tag);
        check("stall_head_tag", bus.out_tag, 2);
        bus.out_ready = 1'b1;
        wait_drain();

        // Tag wrap: 257 back-to-back beats from a fresh counter
        do_reset();
        for (int i = 0; i < 257; i++)
            send_model(4'(i), 4'(i * 3), 1'(i), 1'(i >> 1));
        wait_drain();

        // Flush a stalled beat with a coincident input beat
        bus.out_ready = 1'b0;
        send_model(4'd9, 4'd6, 1'b1, 1'b0);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_a = 4'd7; bus.in_b = 4'd1;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        // Tag after flush must be 2: wrap left 1, the stalled beat took 1
        send(4'b1100, 4'b1010, 1'b0, 1'b1, 4'b1000, 4'b0110, 1'b1);
        wait_drain();
        check("post_flush_tag_model", exp_tag, 3);

        // Asynchronous reset mid-stall
        bus.out_ready = 1'b0;
        send_model(4'd15, 4'd15, 1'b0, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_g", bus.out_g, 0);
        check("arst_out_p", bus.out_p, 0);
        check("arst_out_cin", bus.out_cin, 0);
        check("arst_out_tag", bus.out_tag, 0);
        sb.delete();
        exp_tag = 8'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("arst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        bp = ~4'd2;
        send(4'd6, 4'd2, 1'b1, 1'b0, 4'd6 & bp, 4'd6 ^ bp, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
